// File: rtl/uart_rx_ctrl.sv
// UART receive controller: enable FSM, 16x sampling-tick generator, FWFT byte
// FIFO between the receiver datapath and the consumer, plus sticky status.
module uart_rx_ctrl #(
  parameter int DIV_W = 16,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_baud_div,
  output logic             o_sampling,
  input  logic [7:0]       i_rx_byte,
  input  logic             i_rx_complete,
  input  logic             i_rx_error,
  output logic             o_rx_valid,
  output logic [7:0]       o_rx_data,
  input  logic             i_rx_ready,
  output logic [AW:0]      o_level,
  output logic             o_overrun,
  output logic [7:0]       o_err_cnt,
  input  logic             i_clr_status,
  output logic [1:0]       o_state
);

  // Debug encoding on o_state: 0 = OFF, 1 = RUN, 2 = DRAIN.
  typedef enum logic [1:0] {
    OFF   = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  state_t           state;
  logic [DIV_W-1:0] tick_cnt;
  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      level;

  logic full;
  logic pop;
  logic good;
  logic push;
  logic ovr_evt;
  logic err_evt;

  // Consumer handshake: a byte transfers on any cycle where o_rx_valid and
  // i_rx_ready are both high; o_rx_data is stable while valid waits for ready.
  assign full    = (level == FULL_LVL);
  assign pop     = (level != '0) & i_rx_ready;
  assign good    = (state == RUN) & i_rx_complete & ~i_rx_error;
  assign push    = good & (~full | pop);
  assign ovr_evt = good & full & ~pop;
  assign err_evt = (state == RUN) & i_rx_error;

  assign o_rx_valid = (level != '0);
  assign o_rx_data  = o_rx_valid ? mem[rd_ptr] : 8'h00;
  assign o_level    = level;
  assign o_state    = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= OFF;
      tick_cnt   <= '0;
      o_sampling <= 1'b0;
    end else begin
      case (state)
        OFF:     if (i_en) state <= RUN;
        RUN:     if (!i_en) state <= DRAIN;
        DRAIN:   if (i_en) state <= RUN;
                 else if (level == '0) state <= OFF;
        default: state <= OFF;
      endcase
      // Only count while staying in RUN so no tick escapes into DRAIN.
      if (state == RUN && i_en) begin
        if (tick_cnt >= i_baud_div) begin
          tick_cnt   <= '0;
          o_sampling <= 1'b1;
        end else begin
          tick_cnt   <= tick_cnt + 1'b1;
          o_sampling <= 1'b0;
        end
      end else begin
        tick_cnt   <= '0;
        o_sampling <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= i_rx_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
    end else begin
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // A same-cycle event beats a clear so no incident is ever lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_overrun <= 1'b0;
      o_err_cnt <= 8'h00;
    end else begin
      if (ovr_evt)           o_overrun <= 1'b1;
      else if (i_clr_status) o_overrun <= 1'b0;

      if (err_evt) begin
        if (i_clr_status)            o_err_cnt <= 8'h01;
        else if (o_err_cnt != 8'hFF) o_err_cnt <= o_err_cnt + 8'h01;
      end else if (i_clr_status) begin
        o_err_cnt <= 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: directed scenarios plus a random phase, every cycle
// compared against a queue-based model of the controller's behaviour.
module tb_uart_rx_ctrl;

  localparam int DIV_W = 16;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [DIV_W-1:0] baud_div;
  logic             sampling;
  logic [7:0]       rx_byte;
  logic             rx_complete;
  logic             rx_error;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             rx_ready;
  logic [AW:0]      level;
  logic             overrun;
  logic [7:0]       err_cnt;
  logic             clr_status;
  logic [1:0]       state;

  uart_rx_ctrl #(.DIV_W(DIV_W), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_en         (en),
    .i_baud_div   (baud_div),
    .o_sampling   (sampling),
    .i_rx_byte    (rx_byte),
    .i_rx_complete(rx_complete),
    .i_rx_error   (rx_error),
    .o_rx_valid   (rx_valid),
    .o_rx_data    (rx_data),
    .i_rx_ready   (rx_ready),
    .o_level      (level),
    .o_overrun    (overrun),
    .o_err_cnt    (err_cnt),
    .i_clr_status (clr_status),
    .o_state      (state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Reference model: mode 0 = OFF, 1 = RUN, 2 = DRAIN.
  logic [7:0] exp_q[$];
  int         m_mode;
  int         m_age;
  bit         m_samp;
  bit         m_ovr;
  int         m_err;
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    int  sz;
    bit  do_pop;
    bit  good;
    bit  ovr_e;
    bit  err_e;
    if (rst) begin
      exp_q.delete();
      m_mode = 0; m_age = 0; m_samp = 0; m_ovr = 0; m_err = 0;
      return;
    end
    sz     = exp_q.size();
    do_pop = (sz > 0) && rx_ready;
    good   = (m_mode == 1) && rx_complete && !rx_error;
    ovr_e  = good && (sz == DEPTH) && !do_pop;
    err_e  = (m_mode == 1) && rx_error;
    if (do_pop) void'(exp_q.pop_front());
    if (good && !ovr_e) exp_q.push_back(rx_byte);
    if (ovr_e) m_ovr = 1;
    else if (clr_status) m_ovr = 0;
    if (err_e) m_err = clr_status ? 1 : (m_err < 255 ? m_err + 1 : 255);
    else if (clr_status) m_err = 0;
    if (m_mode == 1 && en) begin
      m_age++;
      m_samp = (m_age % (int'(baud_div) + 1)) == 0;
    end else begin
      m_samp = 0;
    end
    case (m_mode)
      0: if (en) begin m_mode = 1; m_age = 0; end
      1: if (!en) m_mode = 2;
      default: if (en) begin m_mode = 1; m_age = 0; end
               else if (sz == 0) m_mode = 0;
    endcase
  endtask

  // One clock: model and DUT advance together, then outputs are compared.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("sampling", sampling, m_samp);
    check("valid", rx_valid, exp_q.size() > 0);
    check("data", rx_data, exp_q.size() > 0 ? exp_q[0] : 8'h00);
    check("level", level, exp_q.size());
    check("overrun", overrun, m_ovr);
    check("err_cnt", err_cnt, m_err);
    check("state", state, m_mode);
  endtask

  task automatic push_byte(input logic [7:0] b);
    rx_byte = b; rx_complete = 1'b1;
    step();
    rx_complete = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; baud_div = 16'd3; rx_byte = 8'h00;
    rx_complete = 1'b0; rx_error = 1'b0; rx_ready = 1'b0; clr_status = 1'b0;
    step(); step();
    check("rst_level", level, 0);
    check("rst_state", state, 0);
    rst = 1'b0;

    // Tick generator: div 3, then div 0, then disabled
    en = 1'b1;
    repeat (24) step();
    en = 1'b0;
    repeat (3) step();
    check("off_after_run", state, 0);
    baud_div = 16'd0; en = 1'b1;
    repeat (10) step();
    check("div0_tick", sampling, 1);
    en = 1'b0;
    repeat (10) step();
    check("no_tick_off", sampling, 0);

    // Two bytes queued then drained in order
    baud_div = 16'd3; en = 1'b1;
    step();
    push_byte(8'hA5);
    push_byte(8'h3C);
    check("two_level", level, 2);
    check("two_head", rx_data, 8'hA5);
    rx_ready = 1'b1;
    step();
    check("second_head", rx_data, 8'h3C);
    step();
    check("drained_valid", rx_valid, 0);
    rx_ready = 1'b0;

    // Overflow, then full with simultaneous push and pop
    for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i));
    check("full_level", level, 4);
    check("full_ovr", overrun, 1);
    check("full_head", rx_data, 8'h10);
    clr_status = 1'b1; step(); clr_status = 1'b0;
    check("ovr_cleared", overrun, 0);
    rx_ready = 1'b1;
    push_byte(8'h77);
    rx_ready = 1'b0;
    check("pushpop_level", level, 4);
    check("pushpop_ovr", overrun, 0);
    rx_ready = 1'b1;
    repeat (4) step();
    rx_ready = 1'b0;
    check("flush_valid", rx_valid, 0);

    // Error counter saturation, error beats complete, error beats clear
    rx_error = 1'b1;
    repeat (260) step();
    rx_error = 1'b0;
    check("err_sat", err_cnt, 255);
    clr_status = 1'b1; step(); clr_status = 1'b0;
    check("err_clr", err_cnt, 0);
    rx_error = 1'b1;
    push_byte(8'h55);
    rx_error = 1'b0;
    check("err_nopush", level, 0);
    check("err_one", err_cnt, 1);
    rx_error = 1'b1; clr_status = 1'b1;
    step();
    rx_error = 1'b0; clr_status = 1'b0;
    check("err_beats_clr", err_cnt, 1);

    // Drain: bytes survive disable, OFF only once empty
    push_byte(8'hC1);
    push_byte(8'hC2);
    en = 1'b0;
    step();
    check("drain_state", state, 2);
    repeat (6) step();
    check("drain_level", level, 2);
    rx_ready = 1'b1;
    step(); step();
    rx_ready = 1'b0;
    check("drain_still", state, 2);
    step();
    check("drain_off", state, 0);

    // Reset discards queued bytes
    en = 1'b1;
    step();
    push_byte(8'h01); push_byte(8'h02); push_byte(8'h03);
    check("pre_rst_level", level, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_flush_level", level, 0);
    check("rst_flush_valid", rx_valid, 0);

    // Randomized traffic with a fixed divisor
    en = 1'b0; step();
    baud_div = 16'd2;
    for (int i = 0; i < 3000; i++) begin
      en          = ($urandom_range(0, 9) != 0);
      rx_complete = ($urandom_range(0, 2) == 0);
      rx_error    = ($urandom_range(0, 15) == 0);
      rx_ready    = ($urandom_range(0, 3) == 0);
      clr_status  = ($urandom_range(0, 31) == 0);
      rst         = ($urandom_range(0, 199) == 0);
      rx_byte     = 8'($urandom_range(0, 255));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter DIV_W, default 16, width of the baud divisor and the tick counter.
REQ-002 Parameter DEPTH, default 4, receive FIFO entries (power of two, >=2).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 i_en  input  1  receive enable.
REQ-006 i_baud_div  input  DIV_W  sampling-tick period in clk cycles minus 1 (16x oversample tick).
REQ-007 o_sampling  output  1  one-cycle sampling tick to the receiver datapath.
REQ-008 i_rx_byte  input  8  received byte from the receiver datapath.
REQ-009 i_rx_complete  input  1  one-cycle pulse: i_rx_byte is a good frame.
REQ-010 i_rx_error  input  1  one-cycle pulse: stop-bit error.
REQ-011 o_rx_valid  output  1  FIFO head available.
REQ-012 o_rx_data  output  8  FIFO head byte.
REQ-013 i_rx_ready  input  1  consumer accepts head.
REQ-014 o_level  output  clog2(DEPTH)+1  FIFO occupancy.
REQ-015 o_overrun  output  1  sticky: a good byte was dropped.
REQ-016 o_err_cnt  output  8  saturating frame-error count.
REQ-017 i_clr_status  input  1  clears o_overrun and o_err_cnt.

Function
REQ-018 Controller FSM SHALL have states OFF, RUN, DRAIN; OFF->RUN when i_en=1; RUN->DRAIN when i_en=0; DRAIN->RUN when i_en=1; DRAIN->OFF when i_en=0 and FIFO empty.
REQ-019 Tick counter SHALL run only in RUN; elsewhere held at 0 with o_sampling=0.
REQ-020 In RUN, o_sampling SHALL be 1 for one cycle when counter >= i_baud_div, counter then reloading 0; otherwise counter increments by 1.
REQ-021 i_baud_div=0 SHALL produce o_sampling=1 every RUN cycle; first tick after entering RUN occurs i_baud_div+1 cycles after the RUN transition.
REQ-022 i_rx_complete/i_rx_error SHALL be acted on only in RUN; ignored in OFF and DRAIN.
REQ-023 FIFO SHALL be first-word-fall-through: o_rx_valid = (o_level!=0), o_rx_data = head entry.
REQ-024 Pop SHALL occur when o_rx_valid & i_rx_ready, in any state.
REQ-025 Push of i_rx_byte SHALL occur on i_rx_complete=1, i_rx_error=0 in RUN when not full, or when full with a pop in the same cycle.
REQ-026 Push-to-valid latency SHALL be 1 cycle (byte visible on o_rx_data the cycle after the pulse when FIFO was empty).
REQ-027 Simultaneous push and pop SHALL leave o_level unchanged; pointers wrap modulo DEPTH.
REQ-028 Push when full without pop SHALL drop the byte, leave FIFO unchanged, set o_overrun.
REQ-029 i_rx_error=1 in RUN SHALL increment o_err_cnt, saturating at 255; no push occurs even if i_rx_complete=1 the same cycle.
REQ-030 i_clr_status=1 SHALL zero o_overrun and o_err_cnt next cycle, except a same-cycle overrun/error event SHALL win (o_overrun=1, or o_err_cnt=1).
REQ-031 o_level SHALL never exceed DEPTH nor underflow; pop when empty has no effect.

Reset
REQ-032 rst=1 SHALL force state OFF, tick counter 0, FIFO empty, o_sampling=0, o_rx_valid=0, o_rx_data=0, o_level=0, o_overrun=0, o_err_cnt=0, on the next clk edge, overriding all other inputs.
REQ-033 rst mid-frame or with FIFO non-empty SHALL discard all stored bytes; no pop is reported for them.

Verification
REQ-034 i_en=1, i_baud_div=3 -> o_sampling pulses every 4 cycles; i_baud_div=0 -> every cycle; i_en=0 -> no pulses.
REQ-035 Push 0xA5, 0x3C with i_rx_ready=0 -> o_level=2, o_rx_data=0xA5; raise ready -> 0xA5 then 0x3C popped, o_rx_valid falls.
REQ-036 DEPTH=4, five pushes, ready=0 -> o_level=4, o_overrun=1, fifth byte absent; full + push + pop same cycle -> o_level stays 4, no overrun.
REQ-037 260 i_rx_error pulses -> o_err_cnt=255; complete+error same cycle -> no push, count +1; i_clr_status with error pulse same cycle -> o_err_cnt=1.
REQ-038 Two bytes queued, drop i_en -> state DRAIN, no ticks, bytes still deliverable, OFF after last pop; rst asserted with 3 bytes queued -> o_level=0, o_rx_valid=0 next cycle.
